// File: rtl/sd_write_sequencer.sv
// sd_write_sequencer
// Drives the bootstrap SPI/SD engine through one single-block write:
// init handshake (first time only), CMD24 frame, data-token frame, then
// waits for write complete. Each wait phase has a timeout. A timeout after
// the command has been issued restarts from the command frame a bounded
// number of times.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for wr_req_i; captures address/data on request
// INIT  | bootstrap_init_o high, waiting for bootstrap_initdone_i
// CMD   | CMD24 frame presented, waiting for flag 100 (command sent)
// TOKEN | data-token frame presented, waiting for flag 101 (data sent)
// WBUSY | line idle (all ones), waiting for flag 110 (write complete)
// DONE  | one-cycle success pulse; requests are not accepted here
// ERR   | sets the sticky error, returns to IDLE
module sd_write_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic        master_clk_i,
  input  logic        master_rst_i,
  input  logic        wr_req_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic        bootstrap_initdone_i,
  input  logic [2:0]  spi_flagreg_i,
  output logic        bootstrap_init_o,
  output logic [47:0] spi_data_o,
  output logic [8:0]  spi_statusreg_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_CMD   = 3'd2,
    ST_TOKEN = 3'd3,
    ST_WBUSY = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYC - 1);
  localparam logic [2:0]  RETRY_LIMIT = 3'(MAX_RETRY);

  localparam logic [2:0]  FLAG_CMD    = 3'b100;
  localparam logic [2:0]  FLAG_TOKEN  = 3'b101;
  localparam logic [2:0]  FLAG_WDONE  = 3'b110;

  localparam logic [8:0]  STAT_OFF    = 9'h000;
  localparam logic [8:0]  STAT_INIT   = 9'h1A3;
  localparam logic [8:0]  STAT_XFER   = 9'h1A7;

  localparam logic [47:0] FRAME_IDLE  = 48'hFFFF_FFFF_FFFF;

  state_t      state;
  state_t      state_nxt;
  logic        init_ok;
  logic        init_ok_nxt;
  logic [2:0]  retry;
  logic [2:0]  retry_nxt;
  logic [15:0] tmo;
  logic [15:0] tmo_nxt;
  logic [31:0] addr;
  logic [31:0] addr_nxt;
  logic [31:0] data;
  logic [31:0] data_nxt;
  logic        err;
  logic        err_nxt;

  // Phase bookkeeping shared by the three transfer wait states.
  logic        tmo_hit;
  logic        flag_hit;
  state_t      adv_state;

  assign tmo_hit = (tmo == TMO_LAST);

  // Expected flag and successor for whichever transfer phase is active.
  always_comb begin
    flag_hit  = 1'b0;
    adv_state = ST_IDLE;
    unique case (state)
      ST_CMD: begin
        flag_hit  = (spi_flagreg_i == FLAG_CMD);
        adv_state = ST_TOKEN;
      end
      ST_TOKEN: begin
        flag_hit  = (spi_flagreg_i == FLAG_TOKEN);
        adv_state = ST_WBUSY;
      end
      ST_WBUSY: begin
        flag_hit  = (spi_flagreg_i == FLAG_WDONE);
        adv_state = ST_DONE;
      end
      default: begin
        flag_hit  = 1'b0;
        adv_state = ST_IDLE;
      end
    endcase
  end

  // Next-state and next-register values.
  always_comb begin
    state_nxt   = state;
    init_ok_nxt = init_ok;
    retry_nxt   = retry;
    tmo_nxt     = tmo;
    addr_nxt    = addr;
    data_nxt    = data;
    err_nxt     = err;

    unique case (state)
      ST_IDLE: begin
        if (wr_req_i) begin
          addr_nxt  = wr_addr_i;
          data_nxt  = wr_data_i;
          err_nxt   = 1'b0;
          retry_nxt = '0;
          tmo_nxt   = '0;
          state_nxt = init_ok ? ST_CMD : ST_INIT;
        end
      end

      ST_INIT: begin
        tmo_nxt = tmo + 16'd1;
        if (bootstrap_initdone_i) begin
          init_ok_nxt = 1'b1;
          tmo_nxt     = '0;
          state_nxt   = ST_CMD;
        end else if (tmo_hit) begin
          // Init failures are not retried; the next request tries again.
          state_nxt = ST_ERR;
        end
      end

      ST_CMD, ST_TOKEN, ST_WBUSY: begin
        tmo_nxt = tmo + 16'd1;
        // The expected flag takes priority over a same-cycle timeout.
        if (flag_hit) begin
          tmo_nxt   = '0;
          state_nxt = adv_state;
        end else if (tmo_hit) begin
          if (retry < RETRY_LIMIT) begin
            retry_nxt = retry + 3'd1;
            tmo_nxt   = '0;
            state_nxt = ST_CMD;
          end else begin
            state_nxt = ST_ERR;
          end
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
      end

      ST_ERR: begin
        err_nxt   = 1'b1;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge master_clk_i) begin
    if (!master_rst_i) begin
      state   <= ST_IDLE;
      init_ok <= 1'b0;
      retry   <= '0;
      tmo     <= '0;
      addr    <= '0;
      data    <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      init_ok <= init_ok_nxt;
      retry   <= retry_nxt;
      tmo     <= tmo_nxt;
      addr    <= addr_nxt;
      data    <= data_nxt;
      err     <= err_nxt;
    end
  end

  // Moore output decode from the registered state and captured payload.
  always_comb begin
    bootstrap_init_o = 1'b0;
    spi_data_o       = FRAME_IDLE;
    spi_statusreg_o  = STAT_OFF;
    busy_o           = (state != ST_IDLE);
    done_o           = 1'b0;
    err_o            = err;

    unique case (state)
      ST_INIT: begin
        bootstrap_init_o = 1'b1;
        spi_statusreg_o  = STAT_INIT;
      end
      ST_CMD: begin
        spi_data_o      = {8'h58, addr, 8'hFF};
        spi_statusreg_o = STAT_XFER;
      end
      ST_TOKEN: begin
        spi_data_o      = {8'hFE, data, 8'h00};
        spi_statusreg_o = STAT_XFER;
      end
      ST_WBUSY: begin
        spi_statusreg_o = STAT_XFER;
      end
      ST_DONE: begin
        done_o = 1'b1;
      end
      default: begin
        bootstrap_init_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sd_write_sequencer.sv
// Bench for sd_write_sequencer. A timeline of per-cycle records {inputs,
// expected outputs} is built up front from phase durations (how many cycles
// each wait lasts given when its flag shows up), then replayed in one loop.
module tb_sd_write_sequencer;

  localparam int TMO   = 16;
  localparam int RET   = 2;
  localparam int NEVER = 99;

  localparam int P_IDLE  = 0;
  localparam int P_INIT  = 1;
  localparam int P_CMD   = 2;
  localparam int P_TOKEN = 3;
  localparam int P_WBUSY = 4;
  localparam int P_DONE  = 5;
  localparam int P_ERR   = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        initdone;
  logic [2:0]  flag;
  logic        init_o;
  logic [47:0] spi_data;
  logic [8:0]  status;
  logic        busy;
  logic        done;
  logic        err;

  sd_write_sequencer #(.TIMEOUT_CYC(TMO), .MAX_RETRY(RET)) dut (
    .master_clk_i         (clk),
    .master_rst_i         (rst_n),
    .wr_req_i             (wr_req),
    .wr_addr_i            (wr_addr),
    .wr_data_i            (wr_data),
    .bootstrap_initdone_i (initdone),
    .spi_flagreg_i        (flag),
    .bootstrap_init_o     (init_o),
    .spi_data_o           (spi_data),
    .spi_statusreg_o      (status),
    .busy_o               (busy),
    .done_o               (done),
    .err_o                (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        req;
    logic        initdone;
    logic [2:0]  flag;
    logic [31:0] addr;
    logic [31:0] data;
    bit          chk;
    bit          chk_spi;
    bit          chk_stat;
    logic        e_init;
    logic        e_busy;
    logic        e_done;
    logic        e_err;
    logic [47:0] e_spi;
    logic [8:0]  e_stat;
  } cyc_t;

  cyc_t        plan[$];
  bit          m_init_ok;
  bit          m_err;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  int          n_chk;
  int          n_fail;

  task automatic check(input string name, input int cyc, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at step %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [2:0] rnd_flag_not(input logic [2:0] want);
    logic [2:0] f;
    f = 3'($urandom_range(0, 7));
    while (f == want) f = 3'($urandom_range(0, 7));
    return f;
  endfunction

  // Append one cycle; expected outputs follow from the phase the DUT is in.
  task automatic push(input int ph, input logic req, input logic idn, input logic [2:0] f,
                      input logic rst, input logic [31:0] a, input logic [31:0] d, input bit chk);
    cyc_t c;
    c.rst      = rst;
    c.req      = req;
    c.initdone = idn;
    c.flag     = f;
    c.addr     = a;
    c.data     = d;
    c.chk      = chk;
    c.e_init   = (ph == P_INIT);
    c.e_busy   = (ph != P_IDLE);
    c.e_done   = (ph == P_DONE);
    c.e_err    = m_err;
    c.chk_stat = (ph <= P_WBUSY);
    c.chk_spi  = (ph == P_IDLE) || (ph == P_CMD) || (ph == P_TOKEN) || (ph == P_WBUSY);
    c.e_stat   = (ph == P_INIT) ? 9'h1A3 : (ph == P_IDLE) ? 9'h000 : 9'h1A7;
    if (ph == P_CMD)        c.e_spi = {8'h58, m_addr, 8'hFF};
    else if (ph == P_TOKEN) c.e_spi = {8'hFE, m_data, 8'h00};
    else                    c.e_spi = 48'hFFFF_FFFF_FFFF;
    plan.push_back(c);
  endtask

  // Busy-phase cycle with stray requests that the DUT must ignore.
  task automatic push_busy(input int ph, input logic idn, input logic [2:0] f, input bit req_all);
    logic r;
    r = req_all || ($urandom_range(0, 7) == 0);
    push(ph, r, idn, f, 1'b1, $urandom, $urandom, 1'b1);
  endtask

  task automatic plan_idle(input int n);
    for (int k = 0; k < n; k++)
      push(P_IDLE, 1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b1, $urandom, $urandom, 1'b1);
  endtask

  task automatic plan_request(input logic [31:0] a, input logic [31:0] d);
    push(P_IDLE, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b1, a, d, 1'b1);
    m_addr = a;
    m_data = d;
    m_err  = 1'b0;
  endtask

  // A wait phase whose flag arrives dly cycles in; dly >= TMO means never.
  task automatic run_phase(input int ph, input logic [2:0] want, input int dly, input bit req_all, output bit ok);
    int n;
    n = (dly < TMO) ? dly : TMO;
    for (int k = 0; k < n; k++)
      push_busy(ph, 1'($urandom_range(0, 1)), rnd_flag_not(want), req_all);
    ok = (dly < TMO);
    if (ok) push_busy(ph, 1'($urandom_range(0, 1)), want, req_all);
  endtask

  task automatic run_init(input int dly, output bit ok);
    int n;
    n = (dly < TMO) ? dly : TMO;
    for (int k = 0; k < n; k++)
      push_busy(P_INIT, 1'b0, 3'($urandom_range(0, 7)), 1'b0);
    ok = (dly < TMO);
    if (ok) push_busy(P_INIT, 1'b1, 3'($urandom_range(0, 7)), 1'b0);
  endtask

  task automatic plan_txn(input logic [31:0] a, input logic [31:0] d, input int gap,
                          input int init_dly, input int dly[9]);
    bit ok;
    plan_idle(gap);
    plan_request(a, d);
    if (!m_init_ok) begin
      run_init(init_dly, ok);
      if (!ok) begin
        push_busy(P_ERR, 1'b0, 3'($urandom_range(0, 7)), 1'b0);
        m_err = 1'b1;
        return;
      end
      m_init_ok = 1'b1;
    end
    for (int at = 0; at <= RET; at++) begin
      run_phase(P_CMD, 3'b100, dly[3*at], 1'b0, ok);
      if (ok) run_phase(P_TOKEN, 3'b101, dly[3*at+1], 1'b0, ok);
      if (ok) run_phase(P_WBUSY, 3'b110, dly[3*at+2], 1'b0, ok);
      if (ok) begin
        push_busy(P_DONE, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b0);
        return;
      end
    end
    push_busy(P_ERR, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b0);
    m_err = 1'b1;
  endtask

  // Reset asserted from the last planned cycle for n cycles in total.
  task automatic plan_reset(input int n);
    plan[plan.size()-1].rst = 1'b0;
    m_init_ok = 1'b0;
    m_err     = 1'b0;
    for (int k = 1; k < n; k++)
      push(P_IDLE, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'b0, $urandom, $urandom, 1'b1);
  endtask

  initial begin
    int dl[9];
    int idl;
    bit ok;
    n_chk     = 0;
    n_fail    = 0;
    m_init_ok = 1'b0;
    m_err     = 1'b0;
    m_addr    = '0;
    m_data    = '0;
    rst_n     = 1'b0;
    wr_req    = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    initdone  = 1'b0;
    flag      = '0;

    // Reset low for three cycles; first cycle precedes any reset edge.
    push(P_IDLE, 1'b0, 1'b0, 3'b000, 1'b0, '0, '0, 1'b0);
    push(P_IDLE, 1'b1, 1'b1, 3'b100, 1'b0, '1, '1, 1'b1);
    push(P_IDLE, 1'b1, 1'b1, 3'b110, 1'b0, '1, '1, 1'b1);

    // Cold write with init handshake.
    dl = '{10, 10, 10, 10, 10, 10, 10, 10, 10};
    plan_txn(32'h0000_4200, 32'h8623_2200, 2, 5, dl);

    // Warm write immediately after DONE: INIT skipped.
    dl = '{3, 4, 5, 0, 0, 0, 0, 0, 0};
    plan_txn(32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 0, dl);

    // Command never acknowledged: three CMD phases then error.
    dl = '{NEVER, 0, 0, NEVER, 0, 0, NEVER, 0, 0};
    plan_txn(32'h1111_2222, 32'h3333_4444, 1, 0, dl);

    // Token withheld on first pass, second pass succeeds; error clears.
    dl = '{10, NEVER, 0, 10, 10, 10, 0, 0, 0};
    plan_txn(32'h5555_6666, 32'h7777_8888, 2, 0, dl);

    // Flags arriving on the very last timeout cycle win over the timeout.
    dl = '{TMO-1, TMO-1, TMO-1, 0, 0, 0, 0, 0, 0};
    plan_txn(32'h0F0F_0F0F, 32'hF0F0_F0F0, 0, 0, dl);

    // Success only on the final permitted attempt.
    dl = '{NEVER, 0, 0, 2, 2, NEVER, 1, 1, 1};
    plan_txn(32'h2468_ACE0, 32'h1357_9BDF, 1, 0, dl);

    // Stray requests during CMD, reset in WBUSY, then re-init on next write.
    plan_idle(1);
    plan_request(32'hA5A5_0001, 32'h1234_5678);
    run_phase(P_CMD, 3'b100, 6, 1'b1, ok);
    run_phase(P_TOKEN, 3'b101, 3, 1'b0, ok);
    for (int k = 0; k < 4; k++) push_busy(P_WBUSY, 1'b0, rnd_flag_not(3'b110), 1'b0);
    plan_reset(3);
    dl = '{2, 2, 2, 0, 0, 0, 0, 0, 0};
    plan_txn(32'hCAFE_0002, 32'h9ABC_DEF0, 1, 4, dl);

    // Init timeout leaves init pending; the following write inits again.
    plan_txn(32'h0000_0001, 32'h0000_0002, 1, NEVER, dl);
    plan_txn(32'h0000_0003, 32'h0000_0004, 0, TMO-1, dl);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 9; k++)
        dl[k] = ($urandom_range(0, 9) == 0) ? NEVER :
                ($urandom_range(0, 3) == 0) ? TMO - 1 : int'($urandom_range(0, TMO - 1));
      idl = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, TMO - 1));
      plan_txn($urandom, $urandom, int'($urandom_range(0, 3)), idl, dl);
      if ($urandom_range(0, 7) == 0) begin
        plan_idle(1);
        plan_reset(int'($urandom_range(1, 3)));
      end
    end
    plan_idle(3);

    @(posedge clk);
    for (int i = 0; i < plan.size(); i++) begin
      #1;
      rst_n    = plan[i].rst;
      wr_req   = plan[i].req;
      wr_addr  = plan[i].addr;
      wr_data  = plan[i].data;
      initdone = plan[i].initdone;
      flag     = plan[i].flag;
      @(negedge clk);
      if (plan[i].chk) begin
        check("busy", i, 48'(busy), 48'(plan[i].e_busy));
        check("done", i, 48'(done), 48'(plan[i].e_done));
        check("err", i, 48'(err), 48'(plan[i].e_err));
        check("init", i, 48'(init_o), 48'(plan[i].e_init));
        if (plan[i].chk_stat) check("status", i, 48'(status), 48'(plan[i].e_stat));
        if (plan[i].chk_spi) check("spi_data", i, spi_data, plan[i].e_spi);
      end
      @(posedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
